twiddle_gen: RTL
================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter N_FFT, default 8, FFT size; power of two, 8..4096.
REQ-002 SHALL have parameter TW_W, default 12, signed twiddle width; amplitude A = 2^(TW_W-1)-1.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one stage sequence; sampled only when busy=0.
REQ-006 SHALL have port stage  input  $clog2(log2(N_FFT))+1  radix-2 DIF stage index, captured with start.
REQ-007 SHALL have port busy  output  1  high from accepted start until the last twiddle is accepted.
REQ-008 SHALL have port tw_valid  output  1  twiddle output valid.
REQ-009 SHALL have port tw_ready  input  1  downstream accepts when tw_valid & tw_ready.
REQ-010 SHALL have port twiddle_re  output  TW_W signed  round(A*cos(2*pi*k/N_FFT)).
REQ-011 SHALL have port twiddle_im  output  TW_W signed  -round(A*sin(2*pi*k/N_FFT)).
REQ-012 SHALL have port done  output  1  one-cycle pulse on the cycle the last twiddle is accepted.
REQ-013 SHALL have port err  output  1  one-cycle pulse when start arrives with stage >= log2(N_FFT).

Function
REQ-014 SHALL store only the quarter wave Q[m] = round(A*cos(2*pi*m/N_FFT)), m = 0..N_FFT/4, computed at elaboration.
REQ-015 SHALL emit exactly N_FFT/2 twiddles per accepted start, output count n = 0..N_FFT/2-1, index k = (n mod (N_FFT >> (stage+1))) << stage.
REQ-016 SHALL map k <= N_FFT/4 to re = Q[k], im = -Q[N_FFT/4-k].
REQ-017 SHALL map N_FFT/4 < k < N_FFT/2 to re = -Q[N_FFT/2-k], im = -Q[k-N_FFT/4].
REQ-018 SHALL use FSM IDLE -> RUN on valid start; RUN -> IDLE when the last twiddle is accepted.
REQ-019 SHALL use a 2-stage pipeline: stage 1 registers the ROM read and quadrant flag, stage 2 registers the sign/select result.
REQ-020 SHALL assert the first tw_valid 2 cycles after the start-accept edge when tw_ready is held high, then sustain one twiddle per cycle.
REQ-021 SHALL freeze index counter, both pipeline stages and outputs while tw_valid=1 and tw_ready=0; no twiddle lost or duplicated.
REQ-022 SHALL ignore start while busy=1, with no err.
REQ-023 SHALL, on invalid stage, pulse err, stay in IDLE and keep busy=0.
REQ-024 SHALL accept a start in the same cycle done pulses (back-to-back sequences, no bubble beyond pipeline latency).
REQ-025 SHALL never produce -2^(TW_W-1); negation of values in [-A, A] cannot overflow.

Reset
REQ-026 SHALL on rst force FSM=IDLE, counter=0, pipeline valids=0, busy=0, tw_valid=0, done=0, err=0, twiddle_re=0, twiddle_im=0.
REQ-027 SHALL let rst override a sequence in progress; no further tw_valid until a new start.
REQ-028 SHALL not reset ROM contents.

Structure
REQ-029 SHALL place the quarter-wave constant function, the FSM state enum and the log2/amplitude localparam helpers in shared package fft_tw_pkg.
REQ-030 SHALL instantiate one sub-module, tw_qrom (synchronous-read quarter-wave ROM, N_FFT/4+1 entries x TW_W-1 unsigned bits).

Verification (N_FFT=8, TW_W=12: Q = 2047, 1447, 0)
REQ-031 SHALL check: stage=0, tw_ready=1 -> (2047,0), (1447,-1447), (0,-2047), (-1447,-1447); done with the 4th.
REQ-032 SHALL check: stage=1 -> (2047,0), (0,-2047), (2047,0), (0,-2047); stage=2 -> (2047,0) x4.
REQ-033 SHALL check: stage=0, tw_ready low for 3 cycles on the 2nd twiddle -> (1447,-1447) held stable; sequence complete with no loss.
REQ-034 SHALL check: stage=3 start -> err pulse 1 cycle, busy=0, no tw_valid.
REQ-035 SHALL check: rst after 2nd twiddle -> all outputs 0 next cycle, IDLE; new start restarts at (2047,0).
REQ-036 SHALL check: N_FFT=1024, TW_W=16, all stages -> every output matches a real-math model within 1 LSB, and count = 512 per start.

Source files
------------

// File: rtl/fft_tw_pkg.sv
// Shared types and elaboration-time helpers for the FFT twiddle generator.
// The quarter-wave table is computed here so the ROM needs no init file.
package fft_tw_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam real PI = 3.14159265358979323846;

  function automatic int lg2(input int n);
    return $clog2(n);
  endfunction

  function automatic int amp(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // round(A*cos(2*pi*m/n)); m <= n/4 keeps the value non-negative
  function automatic logic [31:0] qw(
    input int m,
    input int n,
    input int w
  );
    real v;
    v = real'(amp(w)) * $cos(2.0 * PI * real'(m) / real'(n));
    return 32'($rtoi(v + 0.5));
  endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Twiddle output stream: valid/ready handshake plus signed re/im.
// The generator drives the master side, the consumer the slave side.
interface twiddle_gen_if #(
  parameter int TW_W = 12
);
  logic                   tw_valid;
  logic                   tw_ready;
  logic signed [TW_W-1:0] twiddle_re;
  logic signed [TW_W-1:0] twiddle_im;

  modport master (
    output tw_valid,
    output twiddle_re,
    output twiddle_im,
    input  tw_ready
  );

  modport slave (
    input  tw_valid,
    input  twiddle_re,
    input  twiddle_im,
    output tw_ready
  );
endinterface

// File: rtl/tw_qrom.sv
// Quarter-wave cosine ROM, two synchronous read ports.
// Contents are constants; only the read registers are clocked.
module tw_qrom
  import fft_tw_pkg::*;
#(
  parameter int N_FFT = 8,
  parameter int TW_W  = 12
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(N_FFT)-2:0] addr_a,
  input  logic [$clog2(N_FFT)-2:0] addr_b,
  output logic [TW_W-2:0]          q_a,
  output logic [TW_W-2:0]          q_b
);
  localparam int DEPTH = N_FFT / 4 + 1;

  logic [TW_W-2:0] rom [DEPTH];

  for (genvar m = 0; m < DEPTH; m++) begin : g_rom
    localparam logic [31:0] V = qw(m, N_FFT, TW_W);
    assign rom[m] = V[TW_W-2:0];
  end

  always_ff @(posedge clk) begin
    if (en) begin
      q_a <= rom[addr_a];
      q_b <= rom[addr_b];
    end
  end
endmodule

// File: rtl/twiddle_gen.sv
// Radix-2 DIF twiddle sequencer: N_FFT/2 twiddles per stage request,
// built from a quarter-wave ROM with a 2-deep stallable pipeline.
module twiddle_gen
  import fft_tw_pkg::*;
#(
  parameter int N_FFT = 8,
  parameter int TW_W  = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2($clog2(N_FFT)):0] stage,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  twiddle_gen_if.master                  tw
);
  localparam int LG = lg2(N_FFT);
  localparam int AW = LG - 1;
  localparam int SW = $clog2(LG) + 1;
  localparam logic [SW-1:0] STG_LIM = SW'(LG);
  localparam logic [AW-1:0] ONES = '1;
  localparam logic [AW-1:0] QTR = AW'(N_FFT / 4);
  localparam logic [LG-1:0] LAST = LG'(N_FFT / 2 - 1);

  state_t state_q, state_d;

  logic [LG-1:0] n_q;
  logic [SW-1:0] stg_q;
  logic          v1_q, l1_q, neg_q, l2_q;
  logic [TW_W-2:0] qa, qb;
  logic [AW-1:0] k, addr_a, addr_b;
  logic          adv, fire, issue, take, bad, hi;
  logic signed [TW_W-1:0] ra, rb;

  assign busy  = (state_q == RUN);
  assign adv   = !tw.tw_valid || tw.tw_ready;
  assign fire  = tw.tw_valid && tw.tw_ready;
  assign done  = fire && l2_q;
  // a new request may land on the same edge the last twiddle leaves
  assign take  = start && (!busy || done);
  assign bad   = (stage >= STG_LIM);
  assign issue = busy && adv && !n_q[LG-1];

  assign k      = (n_q[AW-1:0] & (ONES >> stg_q)) << stg_q;
  assign hi     = (k > QTR);
  assign addr_a = hi ? (~k + 1'b1) : k;
  assign addr_b = hi ? (k - QTR) : (QTR - k);

  assign ra = signed'({1'b0, qa});
  assign rb = signed'({1'b0, qb});

  tw_qrom #(
    .N_FFT(N_FFT),
    .TW_W (TW_W)
  ) u_qrom (
    .clk   (clk),
    .en    (adv),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .q_a   (qa),
    .q_b   (qb)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (take && !bad) state_d = RUN;
      RUN:  if (done) state_d = (take && !bad) ? RUN : IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q           <= '0;
      stg_q         <= '0;
      v1_q          <= 1'b0;
      l1_q          <= 1'b0;
      neg_q         <= 1'b0;
      l2_q          <= 1'b0;
      err           <= 1'b0;
      tw.tw_valid   <= 1'b0;
      tw.twiddle_re <= '0;
      tw.twiddle_im <= '0;
    end else begin
      err <= take && bad;
      if (take && !bad) begin
        n_q   <= '0;
        stg_q <= stage;
      end else if (issue) begin
        n_q <= n_q + 1'b1;
      end
      if (adv) begin
        v1_q        <= issue;
        l1_q        <= (n_q == LAST);
        neg_q       <= hi;
        tw.tw_valid <= v1_q;
        l2_q        <= l1_q;
        if (v1_q) begin
          tw.twiddle_re <= neg_q ? -ra : ra;
          tw.twiddle_im <= -rb;
        end
      end
    end
  end
endmodule
